// File: rtl/msgpu_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : msgpu_bus_pkg
// Brief   : Shared types and constants for the MSGPU MCU-style bus master.
// Revision: 1.0 - initial release
// ============================================================================
package msgpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_HOLD  = 2'd3
  } bus_state_t;

  localparam logic BUS_COMMAND = 1'b1;
  localparam logic BUS_DATA    = 1'b0;

  typedef struct packed {
    logic       read;
    logic       command;
    logic [7:0] data;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage
`default_nettype wire

// File: rtl/msgpu_bus_fifo.sv
`default_nettype none
// ============================================================================
// Module  : msgpu_bus_fifo
// Brief   : Synchronous request queue; extra pointer MSB separates full/empty.
// Revision: 1.0 - initial release
// ============================================================================
module msgpu_bus_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_ADDR_W = $clog2(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("msgpu_bus_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_ADDR_W:0] r_wr_ptr;
  logic [c_ADDR_W:0] r_rd_ptr;
  logic w_push_en;
  logic w_pop_en;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                   (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);

  assign w_push_en  = i_push & ~o_full;
  assign w_pop_en   = i_pop & ~o_empty;
  assign o_pop_data = r_mem[r_rd_ptr[c_ADDR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + (c_ADDR_W + 1)'(1);
      if (w_pop_en)  r_rd_ptr <= r_rd_ptr + (c_ADDR_W + 1)'(1);
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_push_en) r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= i_push_data;
  end

endmodule
`default_nettype wire

// File: rtl/msgpu_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : msgpu_bus_master
// Brief   : Queued 8-bit MCU-style bus master (SETUP / HIGH / HOLD strobe).
// Revision: 1.0 - initial release
// ============================================================================
module msgpu_bus_master
  import msgpu_bus_pkg::*;
#(
  parameter int CLOCK_DIVIDER = 4,
  parameter int SETUP_CYCLES  = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_command,
  input  logic       tx_read,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       mcu_bus_clock,
  output logic       mcu_bus_command_data,
  output logic [7:0] mcu_bus_out,
  output logic       mcu_bus_oe,
  input  logic [7:0] mcu_bus_in
);

  generate
    if (CLOCK_DIVIDER < 1 || CLOCK_DIVIDER > 255 ||
        SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_timing
      $error("msgpu_bus_master: CLOCK_DIVIDER or SETUP_CYCLES out of range");
    end
  endgenerate

  localparam logic [7:0] c_HALF_LOAD  = 8'(CLOCK_DIVIDER - 1);
  localparam logic [7:0] c_SETUP_LOAD = 8'(SETUP_CYCLES - 1);

  bus_state_t  r_state;
  bus_state_t  w_next_state;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_next;
  logic        w_cnt_done;
  logic        w_pop;
  logic        w_capture;
  logic        w_push;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  fifo_entry_t w_push_entry;
  fifo_entry_t w_pop_entry;
  logic        r_ready_en;
  logic        r_cur_read;
  logic        r_bus_clock;
  logic        r_bus_oe;
  logic        r_bus_cd;
  logic [7:0]  r_bus_out;
  logic        r_rx_valid;
  logic [7:0]  r_rx_data;

  // r_ready_en keeps tx_ready low until the first edge after reset release.
  assign tx_ready     = r_ready_en & ~w_fifo_full;
  assign w_push       = tx_valid & tx_ready;
  assign w_push_entry = '{read: tx_read, command: tx_command, data: tx_data};
  assign w_cnt_done   = (r_cnt == 8'd0);

  msgpu_bus_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk        (clock),
    .rst_n      (reset_n),
    .i_push     (w_push),
    .i_push_data(w_push_entry),
    .i_pop      (w_pop),
    .o_pop_data (w_pop_entry),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (!w_fifo_empty) w_next_state = ST_SETUP;
      ST_SETUP: if (w_cnt_done) w_next_state = ST_HIGH;
      ST_HIGH:  if (w_cnt_done) w_next_state = ST_HOLD;
      ST_HOLD:  if (w_cnt_done) w_next_state = w_fifo_empty ? ST_IDLE : ST_SETUP;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Every entry into SETUP (from IDLE or straight out of HOLD) consumes one entry.
  always_comb begin
    w_pop      = (w_next_state == ST_SETUP) && (r_state != ST_SETUP);
    w_capture  = (r_state == ST_HIGH) && w_cnt_done && r_cur_read;
    w_cnt_next = w_cnt_done ? r_cnt : r_cnt - 8'd1;
    if (w_next_state != r_state) begin
      case (w_next_state)
        ST_SETUP:         w_cnt_next = c_SETUP_LOAD;
        ST_HIGH, ST_HOLD: w_cnt_next = c_HALF_LOAD;
        default:          w_cnt_next = 8'd0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= 8'd0;
      r_ready_en  <= 1'b0;
      r_cur_read  <= 1'b0;
      r_bus_clock <= 1'b0;
      r_bus_oe    <= 1'b0;
      r_bus_cd    <= BUS_DATA;
      r_bus_out   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= 8'h00;
    end else begin
      r_cnt       <= w_cnt_next;
      r_ready_en  <= 1'b1;
      r_bus_clock <= (w_next_state == ST_HIGH);
      r_rx_valid  <= w_capture;
      if (w_capture) r_rx_data <= mcu_bus_in;
      if (w_pop) begin
        r_bus_out  <= w_pop_entry.data;
        r_bus_cd   <= w_pop_entry.command;
        r_bus_oe   <= ~w_pop_entry.read;
        r_cur_read <= w_pop_entry.read;
      end else if (w_next_state == ST_IDLE) begin
        r_bus_oe <= 1'b0;
      end
    end
  end

  assign busy                 = ~w_fifo_empty | (r_state != ST_IDLE);
  assign mcu_bus_clock        = r_bus_clock;
  assign mcu_bus_command_data = r_bus_cd;
  assign mcu_bus_out          = r_bus_out;
  assign mcu_bus_oe           = r_bus_oe;
  assign rx_valid             = r_rx_valid;
  assign rx_data              = r_rx_data;

endmodule
`default_nettype wire
